priority_resolver_core: RTL and testbench
=========================================

// Module: priority_resolver_core
//
// PURPOSE
// - 8259A-style priority resolver for eight interrupt request levels (IR0..IR7).
// - Combines IRR, the interrupt mask, ISR and the rotation setting, then selects
//   the single highest-priority request allowed to interrupt.
// - Sits between the IRR/ISR/IMR register block and the control logic that
//   raises INT and runs the INTA sequence.
// - Result is registered: one-hot, at most one bit set.
//
// PARAMETERS
// - none; width is fixed at 8 levels.
//
// PORTS
// clock                        in   1  system clock, rising edge
// reset                        in   1  asynchronous, active-high reset
// priority_rotate              in   3  lowest-priority level; 3'b111 = fixed (IR0 highest)
// interrupt_mask               in   8  IMR; 1 = level masked
// special_fully_nested_config  in   1  1 = special fully nested mode (SFNM)
// highest_level_in_service     in   8  one-hot highest-priority ISR level (SFNM only)
// IRR                          in   8  interrupt request register
// ISR                          in   8  in-service register
// interrupt                    out  8  one-hot level to service; 0 = none
//
// BEHAVIOUR
// - Reset: interrupt = 8'h00 immediately (asynchronous); held at 0 while reset = 1.
// - Latency: interrupt is updated on every rising clock edge from the current
//   inputs. It reflects the inputs sampled one cycle earlier. There is no handshake.
// - Priority order: level (priority_rotate+1) mod 8 is highest, then ascending
//   with wrap-around; priority_rotate itself is lowest.
//   - Example: rotate = 3 gives order IR4 > IR5 > IR6 > IR7 > IR0 > IR1 > IR2 > IR3.
// - rot_r(x) = rotate x right by (priority_rotate+1) mod 8, so the highest level
//   lands at bit 0. rot_l is the inverse.
// - Datapath:
//   1. req = rot_r(IRR & ~interrupt_mask)
//   2. isr = rot_r(ISR)
//   3. In SFNM: hl = rot_r(highest_level_in_service);
//      isr = (isr & ~hl) | {hl[6:0], 1'b0}
//      - The top in-service level no longer blocks itself, so same-level
//        re-entry is allowed.
//   4. pmask: the lowest set bit k of isr gives pmask = (1<<k) - 1; isr = 0 gives 8'hFF.
//      - The in-service level and all lower levels are blocked.
//   5. pick = lowest set bit of (req & pmask), as one-hot (0 if none).
//   6. interrupt_next = rot_l(pick)
// - With SFNM = 0, highest_level_in_service is ignored.
// - With SFNM = 1 and highest_level_in_service = 0, behaviour equals normal mode.
// - Masked levels never win, even when they are higher priority.
// - IRR all zero or all requests masked gives interrupt = 0.
// - Input changes while a result is pending: the result simply follows on the
//   next edge. No state is kept apart from the output register.
//
// STRUCTURE
// - Shared package pic_pkg:
//   - constant PIC_LEVELS = 8
//   - functions rotate_right, rotate_left, resolve_priority (lowest-set-bit
//     one-hot) and priority_mask (from isr)
// - Single module with no sub-modules: combinational resolve plus one 8-bit
//   output register.
//
// TESTING (rotate = 3'b111 and SFNM = 0 unless stated; check one cycle after
// the stimulus is applied)
// - reset = 1 with IRR = FF, mask = 00 -> interrupt = 00 at once.
//   Release reset -> 01 on the next edge.
// - Mask: mask = FF, IRR = 80..FF -> 00.
//   mask = 00: IRR = F0 -> 10; IRR = FF -> 01.
//   mask = 01, IRR = FF -> 02.
// - ISR: ISR = 08, mask = 00, IRR = FF -> 01. IRR = F8 -> 00. IRR = 0C -> 04.
// - SFNM: SFNM = 1, ISR = highest_level_in_service = 08, IRR = F8 -> 08;
//   then SFNM = 0 -> 00.
// - Rotation, mask = 00:
//   - rotate = 0: IRR = 03 -> 02; IRR = 01 -> 01.
//   - rotate = 3: IRR = FF -> 10; IRR = 0F -> 01.
//   - rotate = 6: IRR = 7F -> 01; IRR = C0 -> 80.
// - Rotation with ISR: rotate = 3, ISR = 20, IRR = FF -> 10; IRR = E0 -> 00.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the 8-level priority interrupt controller:
// level count and the rotate / priority helper functions used by the resolver.
package pic_pkg;

  localparam int PIC_LEVELS = 8;

  typedef logic [PIC_LEVELS-1:0] level_vec_t;
  typedef logic [2:0]            level_idx_t;

  // Rotate right by amt: bit (i+amt) mod 8 moves to bit i, so the level named
  // by amt lands at bit 0.
  function automatic level_vec_t rotate_right(input level_vec_t x, input level_idx_t amt);
    level_vec_t y;
    y = '0;
    for (int i = 0; i < PIC_LEVELS; i++) begin
      y[i] = x[3'(i) + amt];
    end
    return y;
  endfunction

  // Inverse of rotate_right: bit i moves back to bit (i+amt) mod 8.
  function automatic level_vec_t rotate_left(input level_vec_t x, input level_idx_t amt);
    level_vec_t y;
    y = '0;
    for (int i = 0; i < PIC_LEVELS; i++) begin
      y[3'(i) + amt] = x[i];
    end
    return y;
  endfunction

  // One-hot of the lowest set bit (bit 0 is highest priority after rotation).
  // Returns zero when nothing is set.
  function automatic level_vec_t resolve_priority(input level_vec_t x);
    return x & (~x + level_vec_t'(1));
  endfunction

  // Levels allowed to interrupt given the rotated in-service vector: every
  // bit strictly below the highest-priority in-service bit. Nothing in
  // service means everything is allowed.
  function automatic level_vec_t priority_mask(input level_vec_t isr);
    level_vec_t lowest;
    lowest = resolve_priority(isr);
    if (lowest == '0) begin
      return '1;
    end
    return lowest - level_vec_t'(1);
  endfunction

endpackage

// File: rtl/priority_resolver_core.sv
// Priority resolver: combines IRR, IMR, ISR and the rotation setting and
// registers a one-hot selection of the single level allowed to interrupt.
module priority_resolver_core
  import pic_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] priority_rotate,
  input  logic [7:0] interrupt_mask,
  input  logic       special_fully_nested_config,
  input  logic [7:0] highest_level_in_service,
  input  logic [7:0] IRR,
  input  logic [7:0] ISR,
  output logic [7:0] interrupt
);

  // The highest-priority level is the one just above the lowest; the 3-bit
  // add wraps 7 -> 0, which makes rotate = 7 the fixed IR0-highest order.
  logic [2:0] rotate_amount;
  assign rotate_amount = priority_rotate + 3'd1;

  logic [7:0] req_rot;
  logic [7:0] isr_rot;
  logic [7:0] hl_rot;
  logic [7:0] isr_eff;
  logic [7:0] allow_mask;
  logic [7:0] pick_rot;
  logic [7:0] interrupt_next;

  // Combinational resolve in the rotated domain, where bit 0 is always the
  // highest-priority level.
  always_comb begin
    req_rot = rotate_right(IRR & ~interrupt_mask, rotate_amount);
    isr_rot = rotate_right(ISR, rotate_amount);
    hl_rot  = rotate_right(highest_level_in_service, rotate_amount);
    isr_eff = isr_rot;
    if (special_fully_nested_config) begin
      // Move the top in-service level's block one step lower so a new
      // request at that same level can still get through.
      isr_eff = (isr_rot & ~hl_rot) | {hl_rot[6:0], 1'b0};
    end
    allow_mask     = priority_mask(isr_eff);
    pick_rot       = resolve_priority(req_rot & allow_mask);
    interrupt_next = rotate_left(pick_rot, rotate_amount);
  end

  // Output register: cleared at once on reset, otherwise follows the resolve.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      interrupt <= '0;
    end else begin
      interrupt <= interrupt_next;
    end
  end

endmodule

// File: tb/tb_priority_resolver_core.sv
// Directed, table-driven bench for priority_resolver_core plus hand-written
// sequences around reset and back-to-back input changes.
module tb_priority_resolver_core;

  logic       clock;
  logic       reset;
  logic [2:0] priority_rotate;
  logic [7:0] interrupt_mask;
  logic       special_fully_nested_config;
  logic [7:0] highest_level_in_service;
  logic [7:0] IRR;
  logic [7:0] ISR;
  logic [7:0] interrupt;

  int total;
  int bad;

  priority_resolver_core dut (
    .clock                       (clock),
    .reset                       (reset),
    .priority_rotate             (priority_rotate),
    .interrupt_mask              (interrupt_mask),
    .special_fully_nested_config (special_fully_nested_config),
    .highest_level_in_service    (highest_level_in_service),
    .IRR                         (IRR),
    .ISR                         (ISR),
    .interrupt                   (interrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [2:0] rot;
    logic [7:0] mask;
    logic       sfnm;
    logic [7:0] hl;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%02h expected=%02h", name, got, exp);
    end else begin
      $display("ok   %s: interrupt=%02h", name, got);
    end
  endtask

  task automatic drive(input vec_t v);
    priority_rotate             = v.rot;
    interrupt_mask              = v.mask;
    special_fully_nested_config = v.sfnm;
    highest_level_in_service    = v.hl;
    IRR                         = v.irr;
    ISR                         = v.isr;
  endtask

  function automatic vec_t mk(input string n, input logic [2:0] rot, input logic [7:0] mask,
                              input logic sfnm, input logic [7:0] hl, input logic [7:0] irr,
                              input logic [7:0] isr, input logic [7:0] exp);
    vec_t v;
    v.name = n; v.rot = rot; v.mask = mask; v.sfnm = sfnm;
    v.hl = hl; v.irr = irr; v.isr = isr; v.exp = exp;
    return v;
  endfunction

  initial begin
    total = 0;
    bad   = 0;

    // Expected values worked out by hand from the rotate / mask rules.
    vecs.push_back(mk("mask_ff_irr_80", 3'd7, 8'hFF, 1'b0, 8'h00, 8'h80, 8'h00, 8'h00));
    vecs.push_back(mk("mask_ff_irr_c3", 3'd7, 8'hFF, 1'b0, 8'h00, 8'hC3, 8'h00, 8'h00));
    vecs.push_back(mk("mask_ff_irr_ff", 3'd7, 8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00));
    vecs.push_back(mk("irr_f0",         3'd7, 8'h00, 1'b0, 8'h00, 8'hF0, 8'h00, 8'h10));
    vecs.push_back(mk("irr_ff",         3'd7, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h01));
    vecs.push_back(mk("mask_01",        3'd7, 8'h01, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h02));
    vecs.push_back(mk("mask_hi_wins_no",3'd7, 8'h0F, 1'b0, 8'h00, 8'h18, 8'h00, 8'h10));
    vecs.push_back(mk("irr_00",         3'd7, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("isr08_irr_ff",   3'd7, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h08, 8'h01));
    vecs.push_back(mk("isr08_irr_f8",   3'd7, 8'h00, 1'b0, 8'h00, 8'hF8, 8'h08, 8'h00));
    vecs.push_back(mk("isr08_irr_0c",   3'd7, 8'h00, 1'b0, 8'h00, 8'h0C, 8'h08, 8'h04));
    vecs.push_back(mk("sfnm_reentry",   3'd7, 8'h00, 1'b1, 8'h08, 8'hF8, 8'h08, 8'h08));
    vecs.push_back(mk("sfnm_off",       3'd7, 8'h00, 1'b0, 8'h08, 8'hF8, 8'h08, 8'h00));
    vecs.push_back(mk("sfnm_hl_zero",   3'd7, 8'h00, 1'b1, 8'h00, 8'hF8, 8'h08, 8'h00));
    vecs.push_back(mk("sfnm_hl_zero_lo",3'd7, 8'h00, 1'b1, 8'h00, 8'h0C, 8'h08, 8'h04));
    vecs.push_back(mk("rot0_irr_03",    3'd0, 8'h00, 1'b0, 8'h00, 8'h03, 8'h00, 8'h02));
    vecs.push_back(mk("rot0_irr_01",    3'd0, 8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 8'h01));
    vecs.push_back(mk("rot3_irr_ff",    3'd3, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h10));
    vecs.push_back(mk("rot3_irr_0f",    3'd3, 8'h00, 1'b0, 8'h00, 8'h0F, 8'h00, 8'h01));
    vecs.push_back(mk("rot3_mask_10",   3'd3, 8'h10, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h20));
    vecs.push_back(mk("rot6_irr_7f",    3'd6, 8'h00, 1'b0, 8'h00, 8'h7F, 8'h00, 8'h01));
    vecs.push_back(mk("rot6_irr_c0",    3'd6, 8'h00, 1'b0, 8'h00, 8'hC0, 8'h00, 8'h80));
    vecs.push_back(mk("rot3_isr20_ff",  3'd3, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h20, 8'h10));
    vecs.push_back(mk("rot3_isr20_e0",  3'd3, 8'h00, 1'b0, 8'h00, 8'hE0, 8'h20, 8'h00));
    vecs.push_back(mk("rot3_sfnm_20",   3'd3, 8'h00, 1'b1, 8'h20, 8'hE0, 8'h20, 8'h20));

    // Reset asserted asynchronously, away from any clock edge.
    drive(mk("init", 3'd7, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00));
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("pre_reset_runs", interrupt, 8'h01);
    #2 reset = 1'b1;
    #1 check("async_reset", interrupt, 8'h00);
    @(posedge clock); #1;
    check("reset_held", interrupt, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("reset_release", interrupt, 8'h01);

    // Table: drive at the falling edge, sample just after the next rising edge.
    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i]);
      @(posedge clock); #1;
      check(vecs[i].name, interrupt, vecs[i].exp);
    end

    // Back-to-back changes: each result follows one edge later, and the old
    // value is still visible just before that edge.
    @(negedge clock);
    drive(mk("seq_a", 3'd7, 8'h00, 1'b0, 8'h00, 8'h40, 8'h00, 8'h40));
    @(posedge clock); #1;
    check("seq_a", interrupt, 8'h40);
    drive(mk("seq_b", 3'd7, 8'h00, 1'b0, 8'h00, 8'h06, 8'h00, 8'h02));
    #2 check("seq_b_before_edge", interrupt, 8'h40);
    @(posedge clock); #1;
    check("seq_b", interrupt, 8'h02);
    IRR = 8'h00;
    @(posedge clock); #1;
    check("seq_c_clear", interrupt, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
